// File: rtl/riscv_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : riscv_hazard_ctrl_pkg
// Purpose  : Shared encodings and shadow-stage record types for the hazard
//            controller of the 5-stage RV32I pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RD          = 2'd0;
    localparam logic [1:0] FWD_W           = 2'd1;
    localparam logic [1:0] FWD_M           = 2'd2;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef logic [4:0] reg_addr_t;

    // Register-use metadata of the instruction sitting in E.
    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      reg_write;
        logic      is_load;
        logic      is_mem;
    } shadow_e_t;

    // Metadata still needed once the instruction has left E.
    typedef struct packed {
        reg_addr_t rd;
        logic      reg_write;
        logic      is_load;
        logic      is_mem;
    } shadow_mw_t;

endpackage

`default_nettype wire

// File: rtl/riscv_hazard_ctrl_if.sv
// ============================================================================
// Module   : riscv_hazard_ctrl_if
// Purpose  : Bundle between the pipeline datapath (master) and the hazard
//            controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_rs1_d;
    logic [4:0]       i_rs2_d;
    logic [4:0]       i_rd_d;
    logic             i_reg_write_d;
    logic [1:0]       i_result_src_d;
    logic             i_mem_write_d;
    logic             i_pc_src_e;
    logic             i_dmem_ready;
    logic [1:0]       o_forward_a_e;
    logic [1:0]       o_forward_b_e;
    logic             o_stall_f;
    logic             o_stall_d;
    logic             o_stall_e;
    logic             o_stall_m;
    logic             o_stall_w;
    logic             o_flush_d;
    logic             o_flush_e;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_rs1_d, i_rs2_d, i_rd_d, i_reg_write_d, i_result_src_d,
               i_mem_write_d, i_pc_src_e, i_dmem_ready,
        input  o_forward_a_e, o_forward_b_e,
               o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w,
               o_flush_d, o_flush_e, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_rs1_d, i_rs2_d, i_rd_d, i_reg_write_d, i_result_src_d,
               i_mem_write_d, i_pc_src_e, i_dmem_ready,
        output o_forward_a_e, o_forward_b_e,
               o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w,
               o_flush_d, o_flush_e, o_stall_cnt, o_flush_cnt
    );

endinterface

`default_nettype wire

// File: rtl/riscv_hazard_ctrl_stage_reg.sv
// ============================================================================
// Module   : riscv_hazard_stage_reg
// Purpose  : Enable/clear register used for the E, M and W shadow stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_hazard_stage_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             i_clk,
    input  wire logic             i_rstn,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;

    // Clear wins over enable so a flushed slot always becomes a bubble.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q <= '0;
        end else if (i_clr) begin
            data_q <= '0;
        end else if (i_en) begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule

`default_nettype wire

// File: rtl/riscv_hazard_ctrl.sv
// ============================================================================
// Module   : riscv_hazard_ctrl
// Purpose  : Forwarding, stall/flush control and perf counters for the
//            5-stage RV32I pipeline, tracked through shadow E/M/W stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_hazard_ctrl
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic          i_clk,
    input  wire logic          i_rstn,
    riscv_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_e_t  w_shd_e_d;
    shadow_e_t  shd_e_q;
    shadow_mw_t w_shd_m_d;
    shadow_mw_t shd_m_q;
    shadow_mw_t shd_w_q;

    logic w_mem_stall;
    logic w_lw_stall;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_stall_w;
    logic w_flush_d, w_flush_e;
    logic w_any_stall, w_any_flush;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_unused;

    function automatic logic [1:0] fwd_sel(
        input reg_addr_t rs,
        input reg_addr_t rd_m,
        input logic      rw_m,
        input reg_addr_t rd_w,
        input logic      rw_w
    );
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end else begin
            return FWD_RD;
        end
    endfunction

    always_comb begin
        w_shd_e_d           = '0;
        w_shd_e_d.rs1       = bus.i_rs1_d;
        w_shd_e_d.rs2       = bus.i_rs2_d;
        w_shd_e_d.rd        = bus.i_rd_d;
        w_shd_e_d.reg_write = bus.i_reg_write_d;
        w_shd_e_d.is_load   = (bus.i_result_src_d == RESULT_SRC_LOAD);
        w_shd_e_d.is_mem    = (bus.i_result_src_d == RESULT_SRC_LOAD) | bus.i_mem_write_d;
    end

    always_comb begin
        w_shd_m_d           = '0;
        w_shd_m_d.rd        = shd_e_q.rd;
        w_shd_m_d.reg_write = shd_e_q.reg_write;
        w_shd_m_d.is_load   = shd_e_q.is_load;
        w_shd_m_d.is_mem    = shd_e_q.is_mem;
    end

    riscv_hazard_stage_reg #(.WIDTH($bits(shadow_e_t))) u_stage_e (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_en   (!w_stall_e),
        .i_clr  (w_flush_e),
        .i_d    (w_shd_e_d),
        .o_q    (shd_e_q)
    );

    riscv_hazard_stage_reg #(.WIDTH($bits(shadow_mw_t))) u_stage_m (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_en   (!w_stall_m),
        .i_clr  (1'b0),
        .i_d    (w_shd_m_d),
        .o_q    (shd_m_q)
    );

    riscv_hazard_stage_reg #(.WIDTH($bits(shadow_mw_t))) u_stage_w (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_en   (!w_stall_w),
        .i_clr  (1'b0),
        .i_d    (shd_m_q),
        .o_q    (shd_w_q)
    );

    // W only needs rd/reg_write; the remaining fields ride along for debug.
    assign w_unused = ^{shd_w_q.is_load, shd_w_q.is_mem};

    assign w_mem_stall = shd_m_q.is_mem & !bus.i_dmem_ready;
    assign w_lw_stall  = shd_e_q.is_load & shd_e_q.reg_write & (shd_e_q.rd != 5'd0) &
                         ((shd_e_q.rd == bus.i_rs1_d) | (shd_e_q.rd == bus.i_rs2_d));

    // A frozen memory access outranks a taken branch: the branch waits in E.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (w_mem_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else if (bus.i_pc_src_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    assign w_any_stall = w_stall_f | w_stall_d | w_stall_e | w_stall_m | w_stall_w;
    assign w_any_flush = w_flush_d | w_flush_e;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (w_any_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.o_forward_a_e = fwd_sel(shd_e_q.rs1, shd_m_q.rd, shd_m_q.reg_write,
                                       shd_w_q.rd, shd_w_q.reg_write);
    assign bus.o_forward_b_e = fwd_sel(shd_e_q.rs2, shd_m_q.rd, shd_m_q.reg_write,
                                       shd_w_q.rd, shd_w_q.reg_write);
    assign bus.o_stall_f     = w_stall_f;
    assign bus.o_stall_d     = w_stall_d;
    assign bus.o_stall_e     = w_stall_e;
    assign bus.o_stall_m     = w_stall_m;
    assign bus.o_stall_w     = w_stall_w;
    assign bus.o_flush_d     = w_flush_d;
    assign bus.o_flush_e     = w_flush_e;
    assign bus.o_stall_cnt   = stall_cnt_q;
    assign bus.o_flush_cnt   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_hazard_ctrl.sv
// ============================================================================
// Module   : tb_riscv_hazard_ctrl
// Purpose  : Directed vector bench for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_hazard_ctrl;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        pc;
        logic        rdy;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [4:0]  stl;   // {f,d,e,m,w}
        logic [1:0]  fls;   // {d,e}
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_errs   = 0;
    vec_t tbl[20];
    vec_t nop_v;

    always #5 clk = ~clk;

    riscv_hazard_ctrl_if #(.CNT_W(32)) bus ();

    riscv_hazard_ctrl #(.CNT_W(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_rs1_d        = v.rs1;
        bus.i_rs2_d        = v.rs2;
        bus.i_rd_d         = v.rd;
        bus.i_reg_write_d  = v.rw;
        bus.i_result_src_d = v.rsrc;
        bus.i_mem_write_d  = v.mw;
        bus.i_pc_src_e     = v.pc;
        bus.i_dmem_ready   = v.rdy;
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [4:0] stl, input logic [1:0] fls);
        chk({tag, " fwd_a"}, 32'(bus.o_forward_a_e), 32'(fa));
        chk({tag, " fwd_b"}, 32'(bus.o_forward_b_e), 32'(fb));
        chk({tag, " stalls"}, 32'({bus.o_stall_f, bus.o_stall_d, bus.o_stall_e,
                                   bus.o_stall_m, bus.o_stall_w}), 32'(stl));
        chk({tag, " flushes"}, 32'({bus.o_flush_d, bus.o_flush_e}), 32'(fls));
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] s, input logic [31:0] f);
        chk({tag, " stall_cnt"}, bus.o_stall_cnt, s);
        chk({tag, " flush_cnt"}, bus.o_flush_cnt, f);
    endtask

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                                input logic mw, input logic pc, input logic rdy);
        vec_t v;
        v = '{rs1, rs2, rd, rw, rsrc, mw, pc, rdy, 2'd0, 2'd0, 5'd0, 2'd0, 32'd0, 32'd0};
        return v;
    endfunction

    initial begin
        //          rs1 rs2 rd rw rsrc mw pc rdy | fa fb stl fls scnt fcnt
        tbl[0]  = '{5'd0,  5'd0, 5'd5,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[1]  = '{5'd5,  5'd1, 5'd7,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[2]  = '{5'd2,  5'd5, 5'd8,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[3]  = '{5'd0,  5'd0, 5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[4]  = '{5'd0,  5'd0, 5'd9,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[5]  = '{5'd0,  5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[6]  = '{5'd2,  5'd0, 5'd6,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd0, 32'd0};
        tbl[7]  = '{5'd3,  5'd6, 5'd10, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b11000, 2'b01, 32'd0, 32'd0};
        tbl[8]  = '{5'd3,  5'd6, 5'd10, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd1, 32'd1};
        tbl[9]  = '{5'd0,  5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 5'b00000, 2'b00, 32'd1, 32'd1};
        tbl[10] = '{5'd0,  5'd0, 5'd11, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd1, 32'd1};
        tbl[11] = '{5'd11, 5'd0, 5'd12, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b11, 32'd1, 32'd1};
        tbl[12] = '{5'd0,  5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd1, 32'd2};
        tbl[13] = '{5'd1,  5'd2, 5'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd1, 32'd2};
        tbl[14] = '{5'd3,  5'd4, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd1, 32'd2};
        tbl[15] = '{5'd0,  5'd0, 5'd13, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 5'b11111, 2'b00, 32'd1, 32'd2};
        tbl[16] = '{5'd0,  5'd0, 5'd13, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 5'b11111, 2'b00, 32'd2, 32'd2};
        tbl[17] = '{5'd0,  5'd0, 5'd13, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 5'b11111, 2'b00, 32'd3, 32'd2};
        tbl[18] = '{5'd0,  5'd0, 5'd13, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b11, 32'd4, 32'd2};
        tbl[19] = '{5'd0,  5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 5'b00000, 2'b00, 32'd4, 32'd3};

        nop_v = mk(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        rstn = 1'b0;
        drive(nop_v);
        @(negedge clk);
        chk_ctrl("reset", 2'd0, 2'd0, 5'b0, 2'b0);
        chk_cnt("reset", 32'd0, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk_ctrl($sformatf("v%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].stl, tbl[i].fls);
            chk_cnt($sformatf("v%0d", i), tbl[i].scnt, tbl[i].fcnt);
            @(posedge clk);
            #1;
        end

        drive(nop_v);
        @(negedge clk);
        chk_cnt("after_table", 32'd4, 32'd3);
        @(posedge clk);
        #1;

        // Build a forward from W and a store stuck in M, then reset mid-stall.
        drive(mk(5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive(mk(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive(mk(5'd5, 5'd0, 5'd6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive(mk(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk_ctrl("pre_rst", 2'd1, 2'd0, 5'b11111, 2'b00);
        #2 rstn = 1'b0;
        #1;
        chk_ctrl("in_rst", 2'd0, 2'd0, 5'b0, 2'b0);
        chk_cnt("in_rst", 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk_ctrl("post_rst", 2'd0, 2'd0, 5'b0, 2'b0);
        @(posedge clk);
        @(negedge clk);
        chk_cnt("post_rst", 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
